// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and constants for the vending datapath
package vending_pkg;

    localparam int AMT_W = 6;

    localparam logic [AMT_W-1:0] NICKEL_C  = 6'd5;
    localparam logic [AMT_W-1:0] DIME_C    = 6'd10;
    localparam logic [AMT_W-1:0] QUARTER_C = 6'd25;

    localparam int PRICE_C = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2
    } acc_state_e;

endpackage

// File: rtl/coin_decoder.sv
// rtl/coin_decoder.sv - combinational coin bits to cents decoder
//   nickel_i, dime_i, quarter_i : coin strobes for this cycle
//   value_o   : cents of the single coin present, 0 if none or illegal
//   present_o : at least one coin strobe is high
//   illegal_o : more than one coin strobe is high
module coin_decoder
    import vending_pkg::*;
(
    input  logic             nickel_i,
    input  logic             dime_i,
    input  logic             quarter_i,
    output logic [AMT_W-1:0] value_o,
    output logic             present_o,
    output logic             illegal_o
);

    always_comb begin
        value_o   = '0;
        illegal_o = 1'b0;
        case ({quarter_i, dime_i, nickel_i})
            3'b000:  value_o = '0;
            3'b001:  value_o = NICKEL_C;
            3'b010:  value_o = DIME_C;
            3'b100:  value_o = QUARTER_C;
            default: illegal_o = 1'b1;
        endcase
    end

    assign present_o = nickel_i | dime_i | quarter_i;

endmodule

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin credit accumulator feeding the dispensing stage
//   Optional refund path enabled by macro COIN_REFUND_EN.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   nickel_i/dime_i/quarter_i : one-cycle coin strobes
//   cancel_i                : refund request (refund build only)
//   deposit_o, exceed_o     : purchase amount and one-cycle purchase pulse
//   balance_o               : current credit
//   coin_reject_o           : one-cycle pulse, sampled coin(s) not accepted
//   refund_valid_o, refund_o: one-cycle refund pulse and amount
module coin_accumulator
    import vending_pkg::*;
#(
    parameter int PRICE = PRICE_C
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             nickel_i,
    input  logic             dime_i,
    input  logic             quarter_i,
    input  logic             cancel_i,
    output logic [AMT_W-1:0] deposit_o,
    output logic             exceed_o,
    output logic [AMT_W-1:0] balance_o,
    output logic             coin_reject_o,
    output logic             refund_valid_o,
    output logic [AMT_W-1:0] refund_o
);

    localparam logic [AMT_W-1:0] PRICE_AMT = AMT_W'(PRICE);

    acc_state_e       state_q, state_d;
    logic [AMT_W-1:0] balance_q, balance_d;
    logic [AMT_W-1:0] deposit_q, deposit_d;
    logic             exceed_q, exceed_d;
    logic             reject_q, reject_d;

    logic [AMT_W-1:0] coin_value;
    logic             coin_present;
    logic             coin_illegal;
    logic [AMT_W-1:0] sum;

    coin_decoder u_coin_decoder (
        .nickel_i  (nickel_i),
        .dime_i    (dime_i),
        .quarter_i (quarter_i),
        .value_o   (coin_value),
        .present_o (coin_present),
        .illegal_o (coin_illegal)
    );

    // Balance stays below PRICE outside VEND, so this cannot exceed PRICE+20.
    assign sum = balance_q + coin_value;

`ifdef COIN_REFUND_EN
    logic             refund_valid_q, refund_valid_d;
    logic [AMT_W-1:0] refund_q, refund_d;
`else
    logic unused_cancel;
    assign unused_cancel = cancel_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            balance_q <= '0;
            deposit_q <= '0;
            exceed_q  <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            deposit_q <= deposit_d;
            exceed_q  <= exceed_d;
            reject_q  <= reject_d;
        end
    end

`ifdef COIN_REFUND_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refund_valid_q <= 1'b0;
            refund_q       <= '0;
        end else begin
            refund_valid_q <= refund_valid_d;
            refund_q       <= refund_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        deposit_d = deposit_q;
        exceed_d  = 1'b0;
        reject_d  = 1'b0;
`ifdef COIN_REFUND_EN
        refund_valid_d = 1'b0;
        refund_d       = '0;
`endif
        case (state_q)
            VEND: begin
                // Single dead cycle after a purchase: everything sampled is refused.
                reject_d = coin_present;
                state_d  = IDLE;
            end
            default: begin
                if (coin_illegal) begin
                    reject_d = 1'b1;
`ifdef COIN_REFUND_EN
                    if (cancel_i && balance_q != '0) begin
                        refund_valid_d = 1'b1;
                        refund_d       = balance_q;
                        balance_d      = '0;
                        state_d        = IDLE;
                    end
`endif
                end
`ifdef COIN_REFUND_EN
                // Cancel wins over a purchase: the whole sum goes back.
                else if (cancel_i && sum != '0) begin
                    refund_valid_d = 1'b1;
                    refund_d       = sum;
                    balance_d      = '0;
                    state_d        = IDLE;
                end
`endif
                else if (coin_present) begin
                    if (sum >= PRICE_AMT) begin
                        deposit_d = sum;
                        exceed_d  = 1'b1;
                        balance_d = '0;
                        state_d   = VEND;
                    end else begin
                        balance_d = sum;
                        state_d   = COLLECT;
                    end
                end
            end
        endcase
    end

    assign deposit_o     = deposit_q;
    assign exceed_o      = exceed_q;
    assign balance_o     = balance_q;
    assign coin_reject_o = reject_q;

`ifdef COIN_REFUND_EN
    assign refund_valid_o = refund_valid_q;
    assign refund_o       = refund_q;
`else
    assign refund_valid_o = 1'b0;
    assign refund_o       = '0;
`endif

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - self-checking bench for coin_accumulator
module tb_coin_accumulator;

    localparam int PRICE = 20;
`ifdef COIN_REFUND_EN
    localparam bit REFUND_EN = 1'b1;
`else
    localparam bit REFUND_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nickel = 1'b0;
    logic       dime = 1'b0;
    logic       quarter = 1'b0;
    logic       cancel = 1'b0;
    logic [5:0] deposit;
    logic       exceed;
    logic [5:0] balance;
    logic       reject;
    logic       refund_valid;
    logic [5:0] refund;

    coin_accumulator #(.PRICE(PRICE)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .nickel_i       (nickel),
        .dime_i         (dime),
        .quarter_i      (quarter),
        .cancel_i       (cancel),
        .deposit_o      (deposit),
        .exceed_o       (exceed),
        .balance_o      (balance),
        .coin_reject_o  (reject),
        .refund_valid_o (refund_valid),
        .refund_o       (refund)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Behavioural model: credit in cents plus "just sold" flag.
    int m_credit  = 0;
    bit m_vend    = 1'b0;
    int m_deposit = 0;
    bit m_exceed  = 1'b0;
    bit m_reject  = 1'b0;
    bit m_refv    = 1'b0;
    int m_refund  = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_balance", int'(balance), m_credit);
            check("cyc_deposit", int'(deposit), m_deposit);
            check("cyc_exceed", int'(exceed), int'(m_exceed));
            check("cyc_reject", int'(reject), int'(m_reject));
            check("cyc_refund_valid", int'(refund_valid), int'(m_refv));
            check("cyc_refund", int'(refund), m_refund);
        end
    end

    task automatic model_reset();
        m_credit = 0; m_vend = 1'b0; m_deposit = 0;
        m_exceed = 1'b0; m_reject = 1'b0; m_refv = 1'b0; m_refund = 0;
    endtask

    task automatic model(input bit n, input bit d, input bit q, input bit c);
        int ncoins;
        int value;
        ncoins = int'(n) + int'(d) + int'(q);
        value  = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
        m_exceed = 1'b0; m_reject = 1'b0; m_refv = 1'b0; m_refund = 0;
        if (m_vend) begin
            m_reject = (ncoins > 0);
            m_vend   = 1'b0;
        end else if (ncoins > 1) begin
            m_reject = 1'b1;
            if (REFUND_EN && c && m_credit > 0) begin
                m_refv = 1'b1; m_refund = m_credit; m_credit = 0;
            end
        end else if (REFUND_EN && c && (m_credit + value) > 0) begin
            m_refv = 1'b1; m_refund = m_credit + value; m_credit = 0;
        end else if (ncoins == 1) begin
            if (m_credit + value >= PRICE) begin
                m_deposit = m_credit + value;
                m_exceed  = 1'b1;
                m_credit  = 0;
                m_vend    = 1'b1;
            end else begin
                m_credit = m_credit + value;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit n, input bit d, input bit q, input bit c);
        nickel = n; dime = d; quarter = q; cancel = c;
        @(posedge clk);
        model(n, d, q, c);
        @(negedge clk);
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_balance", int'(balance), 0);
        check("rst_exceed", int'(exceed), 0);
        check("rst_deposit", int'(deposit), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_refund_valid", int'(refund_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        // dime, dime: purchase at exactly PRICE
        step(0, 1, 0, 0);
        check("lit_dime1_balance", int'(balance), 10);
        step(0, 1, 0, 0);
        check("lit_dime2_exceed", int'(exceed), 1);
        check("lit_dime2_deposit", int'(deposit), 20);
        check("lit_dime2_balance", int'(balance), 0);
        step(0, 0, 0, 0);
        check("lit_vend_exceed_low", int'(exceed), 0);
        check("lit_deposit_hold", int'(deposit), 20);
        step(0, 0, 0, 0);

        // nickel x3, quarter: deposit 40, change 20
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("lit_n3_balance", int'(balance), 15);
        step(0, 0, 1, 0);
        check("lit_n3q_deposit", int'(deposit), 40);
        check("lit_n3q_change", int'(deposit) - PRICE, 20);
        step(0, 0, 0, 0);

        // illegal coin pair with balance 5
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        check("lit_illegal_reject", int'(reject), 1);
        check("lit_illegal_balance", int'(balance), 5);
        check("lit_illegal_exceed", int'(exceed), 0);

        // purchase, then quarter in the VEND cycle
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("lit_40_deposit", int'(deposit), 40);
        step(0, 0, 1, 0);
        check("lit_vend_reject", int'(reject), 1);
        check("lit_vend_balance", int'(balance), 0);
        check("lit_vend_no_exceed", int'(exceed), 0);
        step(0, 0, 0, 0);

        // balance 15, cancel with a dime
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
`ifdef COIN_REFUND_EN
        check("lit_cancel_refv", int'(refund_valid), 1);
        check("lit_cancel_refund", int'(refund), 25);
        check("lit_cancel_exceed", int'(exceed), 0);
`else
        check("lit_nocancel_exceed", int'(exceed), 1);
        check("lit_nocancel_deposit", int'(deposit), 25);
`endif
        check("lit_cancel_balance", int'(balance), 0);
        step(0, 0, 0, 0);

        // cancel alone with zero credit, then cancel with credit only
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // level held for two cycles counts as two coins
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // reset mid-purchase
        model_reset();
        rst_n = 1'b0;
        check_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        step(0, 1, 0, 0);
        check("lit_pre_rst_balance", int'(balance), 10);
        @(posedge clk);
        check_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("lit_async_balance", int'(balance), 0);
        check("lit_async_exceed", int'(exceed), 0);
        check("lit_async_deposit", int'(deposit), 0);
        check("lit_async_reject", int'(reject), 0);
        check("lit_async_refv", int'(refund_valid), 0);
        check("lit_async_refund", int'(refund), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lit_post_rst_refv", int'(refund_valid), 0);
        step(1, 0, 0, 0);
        check("lit_post_rst_balance", int'(balance), 5);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Upstream stage of the vending-machine datapath. Collects one coin per clock (5/10/25 cents), keeps the running credit, and hands a completed purchase to the dispensing stage. On a purchase it emits a one-cycle `exceed_o` pulse alongside the total inserted amount on `deposit_o`. The dispensing stage registers those and computes `soda_o`/`change_o`. An optional cancel path refunds the unspent credit.

## Interface
- `PRICE`, default 20: item price in cents. Must be a multiple of 5 in 5..40. The dispensing stage assumes 20.
- `clk_i`  in  1  single system clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `nickel_i`  in  1  5-cent coin present this cycle.
- `dime_i`  in  1  10-cent coin present this cycle.
- `quarter_i`  in  1  25-cent coin present this cycle.
- `cancel_i`  in  1  refund request. Active only with `COIN_REFUND_EN`.
- `deposit_o`  out  6  total cents inserted for the last completed purchase. Feeds dispensing `deposit_i`.
- `exceed_o`  out  1  one-cycle purchase pulse. Feeds dispensing `exceed_i`.
- `balance_o`  out  6  current credit, for display.
- `coin_reject_o`  out  1  one-cycle pulse: the coin(s) sampled this cycle were not accepted.
- `refund_valid_o`  out  1  one-cycle refund pulse.
- `refund_o`  out  6  refund amount. Valid while `refund_valid_o` is high, 0 otherwise.

## Operation
- Coin value:
  - Exactly one coin input high: the value is 5, 10 or 25.
  - No coin input high: no coin.
  - More than one coin input high: illegal. Pulse `coin_reject_o`; `balance_o` is unchanged.
- Arithmetic is 6-bit unsigned. Let `sum = balance + coin`; its maximum is PRICE-5+25 = PRICE+20 ≤ 60, so it never overflows.
- FSM states: IDLE (balance = 0), COLLECT (0 < balance < PRICE), VEND.
- Transitions from IDLE or COLLECT, when a legal coin is present:
  - If `sum >= PRICE`: set `deposit_o <= sum`, pulse `exceed_o`, clear balance to 0, go to VEND.
  - Otherwise: set balance to `sum` and go to COLLECT.
- With no coin, the state holds.
- VEND:
  - Lasts exactly one cycle, then returns to IDLE.
  - Any coin sampled in VEND is rejected: pulse `coin_reject_o`, credit unchanged.
  - `cancel_i` is ignored in VEND.
- `deposit_o` holds its last value until the next purchase. `exceed_o` is high for exactly one cycle per purchase.
- `balance_o` mirrors the balance register directly; it is not combinational on the inputs.
- Cancel with a legal coin in the same cycle, in IDLE or COLLECT (with macro):
  - Refund `sum` without vending, even if `sum >= PRICE`.
  - Clear balance to 0 and go to IDLE.
- Cancel with an illegal coin in the same cycle: refund only the current balance and also pulse `coin_reject_o`.
- Cancel when the balance is 0 and no coin is present: no effect, no refund pulse.

## Timing
- Reset values: all outputs 0, FSM in IDLE, balance 0.
- Reset asserted mid-purchase discards the credit immediately; no refund is issued.
- Inputs are sampled on the rising edge of `clk_i`. All outputs are registered.
- Latencies:
  - `balance_o`, `coin_reject_o`, `exceed_o` and `deposit_o` update 1 cycle after the sampling edge.
  - The dispensing stage sees `exceed_o` at the following edge, so `soda_o` rises 2 cycles after the coin edge.
- Maximum purchase rate: one per 2 cycles, because of the single VEND cycle.
- Coin inputs are single-cycle pulses from the synchronised coin detector. A level held high for N cycles counts as N coins.

## Configuration
- Macro: `COIN_REFUND_EN`.
- Defined: the `cancel_i` path is present as described in Operation.
- Undefined:
  - `cancel_i` is ignored.
  - `refund_valid_o` and `refund_o` are tied to 0.
  - No refund logic is synthesised.
  - Credit persists until a purchase or reset.

## Structure
- Shared package `vending_pkg` holds:
  - the FSM state enum `acc_state_e` (IDLE, COLLECT, VEND);
  - coin value constants `NICKEL_C=5`, `DIME_C=10`, `QUARTER_C=25`;
  - the default price `PRICE_C=20`;
  - the amount width `AMT_W=6`.
- One sub-module, `coin_decoder`, is natural. It is combinational: it maps the three coin bits to a 6-bit value plus an illegal flag.
- The FSM and registers stay in `coin_accumulator`.

## Test plan
- Reset, then dime, dime → balance 10 after the first coin. After the second: `exceed_o` pulses once with `deposit_o`=20 and the balance returns to 0. Downstream `soda_o`=1, `change_o`=000.
- Nickel×3, then quarter → balance steps 5/10/15. Then `deposit_o`=40 with an `exceed_o` pulse, giving change 20 (`change_o`=100).
- Dime and quarter high together with balance 5 → `coin_reject_o` pulses, balance stays 5, no `exceed_o`.
- Quarter in the cycle immediately after a purchase (VEND) → `coin_reject_o` pulses, balance stays 0, no second `exceed_o`.
- With `COIN_REFUND_EN`: balance 15, then `cancel_i` together with a dime → `refund_valid_o` pulses with `refund_o`=25, no `exceed_o`, balance 0. Without the macro, the same stimulus gives a purchase with `deposit_o`=25.
- Balance 10, then assert `rst_ni` low asynchronously mid-cycle → all outputs 0 immediately, balance 0, no refund pulse after release.
